// File: rtl/eight_bit_adder.sv
// Registered ripple-carry adder/subtractor: a chain of full-adder cells
// feeding a single output register stage gated by in_valid.

module eight_bit_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module eight_bit_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin0,
    input  logic             subtract,
    input  logic             in_valid,
    output logic             Cout,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    // Subtract is a + ~b + 1; Cin0 becomes a borrow by inverting the carry-in.
    assign b_eff = b ^ {WIDTH{subtract}};
    assign c[0]  = Cin0 ^ subtract;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        eight_bit_adder_fa u_fa (
            .a  (a[i]),
            .b  (b_eff[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            Cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= s;
                Cout     <= c[WIDTH];
                overflow <= c[WIDTH] ^ c[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_eight_bit_adder.sv
// Directed and exhaustive checks of eight_bit_adder at WIDTH=4 against
// hand-computed vectors and an arithmetic reference model.

module tb_eight_bit_adder;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Cin0;
    logic             subtract;
    logic             in_valid;
    logic             Cout;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic             out_valid;

    int total = 0;
    int bad   = 0;

    eight_bit_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .Cin0      (Cin0),
        .subtract  (subtract),
        .in_valid  (in_valid),
        .Cout      (Cout),
        .sum       (sum),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive away from the active edge, then sample shortly after it.
    task automatic step(input logic r, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic ci, input logic sub, input logic v);
        @(negedge clk);
        rst_n    = r;
        a        = ta;
        b        = tb;
        Cin0     = ci;
        subtract = sub;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ea, eb, sa, sb, r, rs;
        logic [WIDTH-1:0] esum;
        logic ecout, eovf;

        rst_n = 1'b0; a = '0; b = '0; Cin0 = 1'b0; subtract = 1'b0; in_valid = 1'b0;

        // Reset with in_valid high for two cycles.
        step(1'b0, 4'b0101, 4'b0110, 1'b1, 1'b0, 1'b1);
        step(1'b0, 4'b0101, 4'b0110, 1'b1, 1'b0, 1'b1);
        check("rst_sum",  32'(sum),       32'h0);
        check("rst_cout", 32'(Cout),      32'h0);
        check("rst_ovf",  32'(overflow),  32'h0);
        check("rst_vld",  32'(out_valid), 32'h0);

        step(1'b1, 4'b0100, 4'b0011, 1'b0, 1'b0, 1'b1);
        check("add_sum",  32'(sum),       32'h7);
        check("add_cout", 32'(Cout),      32'h0);
        check("add_ovf",  32'(overflow),  32'h0);
        check("add_vld",  32'(out_valid), 32'h1);

        step(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1);
        check("wrap_sum",  32'(sum),      32'h1);
        check("wrap_cout", 32'(Cout),     32'h1);
        check("wrap_ovf",  32'(overflow), 32'h0);

        step(1'b1, 4'b0100, 4'b0011, 1'b0, 1'b1, 1'b1);
        check("sub_sum",  32'(sum),  32'h1);
        check("sub_cout", 32'(Cout), 32'h1);

        step(1'b1, 4'b0011, 4'b0100, 1'b0, 1'b1, 1'b1);
        check("borrow_sum",  32'(sum),  32'hF);
        check("borrow_cout", 32'(Cout), 32'h0);

        step(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b0, 1'b1);
        check("sovf_sum", 32'(sum),      32'h8);
        check("sovf_ovf", 32'(overflow), 32'h1);

        step(1'b1, 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b1);
        check("subovf_sum",  32'(sum),      32'h7);
        check("subovf_ovf",  32'(overflow), 32'h1);
        check("subovf_cout", 32'(Cout),     32'h1);

        // Hold: new operands without in_valid leave the result registers alone.
        step(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
        check("hold_sum",  32'(sum),       32'h7);
        check("hold_cout", 32'(Cout),      32'h1);
        check("hold_ovf",  32'(overflow),  32'h1);
        check("hold_vld",  32'(out_valid), 32'h0);
        step(1'b1, 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b0);
        check("hold2_sum", 32'(sum),       32'h7);
        check("hold2_vld", 32'(out_valid), 32'h0);

        // Reset mid-stream drops the operation presented on that edge.
        step(1'b1, 4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1);
        check("pre_rst_sum", 32'(sum), 32'h4);
        step(1'b0, 4'b0110, 4'b0001, 1'b0, 1'b0, 1'b1);
        check("mid_rst_sum", 32'(sum),       32'h0);
        check("mid_rst_vld", 32'(out_valid), 32'h0);

        // Exhaustive sweep against an arithmetic reference model.
        for (int sub = 0; sub < 2; sub++) begin
            for (int ci = 0; ci < 2; ci++) begin
                for (int ia = 0; ia < 16; ia++) begin
                    for (int ib = 0; ib < 16; ib++) begin
                        ea = ia;
                        eb = ib;
                        sa = (ia > 7) ? ia - 16 : ia;
                        sb = (ib > 7) ? ib - 16 : ib;
                        if (sub == 0) begin
                            r     = ea + eb + ci;
                            rs    = sa + sb + ci;
                            ecout = (r > 15);
                        end else begin
                            r     = ea - eb - ci;
                            rs    = sa - sb - ci;
                            ecout = (ea >= eb + ci);
                        end
                        esum = 4'(r & 15);
                        eovf = (rs > 7) || (rs < -8);
                        step(1'b1, 4'(ia), 4'(ib), 1'(ci), 1'(sub), 1'b1);
                        check("sweep_sum",  32'(sum),       32'(esum));
                        check("sweep_cout", 32'(Cout),      32'(ecout));
                        check("sweep_ovf",  32'(overflow),  32'(eovf));
                        check("sweep_vld",  32'(out_valid), 32'h1);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
